// File: rtl/rtc_pkg.sv
// rtc_pkg: definitions shared by the RTC up-counter and down-counter.
//   Packed 26-bit time word: [5:0] sec, [11:6] min, [16:12] hour,
//   [21:17] day, [25:22] month. Field boundaries, field maxima (the reload
//   values used on borrow/carry), the timer state encoding and a packing
//   helper live here so both counters agree on one register layout.
package rtc_pkg;

  localparam int TIME_W   = 26;

  localparam int SEC_LSB  = 0;
  localparam int SEC_MSB  = 5;
  localparam int MIN_LSB  = 6;
  localparam int MIN_MSB  = 11;
  localparam int HOUR_LSB = 12;
  localparam int HOUR_MSB = 16;
  localparam int DAY_LSB  = 17;
  localparam int DAY_MSB  = 21;
  localparam int MON_LSB  = 22;
  localparam int MON_MSB  = 25;

  localparam logic [5:0] SEC_MAX  = 6'd59;
  localparam logic [5:0] MIN_MAX  = 6'd59;
  localparam logic [4:0] HOUR_MAX = 5'd23;
  localparam logic [4:0] DAY_MAX  = 5'd30;
  localparam logic [3:0] MON_MAX  = 4'd11;

  typedef logic [TIME_W-1:0] rtc_time_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSE   = 2'd2,
    ST_EXPIRED = 2'd3
  } rtc_state_e;

  function automatic rtc_time_t rtc_pack(input logic [3:0] mon,
                                         input logic [4:0] day,
                                         input logic [4:0] hour,
                                         input logic [5:0] min,
                                         input logic [5:0] sec);
    return {mon, day, hour, min, sec};
  endfunction

endpackage

// File: rtl/rtc_tick_prescaler.sv
// rtc_tick_prescaler: divides clk down to a one-cycle tick every TICK_DIV
// enabled cycles.
//   clk   - system clock
//   reset - asynchronous, active-high; count returns to 0
//   clr   - synchronous clear of the count (wins over en)
//   en    - count advances only while high; count holds when low
//   tick  - high in the enabled cycle where the count equals TICK_DIV-1
module rtc_tick_prescaler
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Gating with en means a held (paused) count never produces a tick.
  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/rtc_downcounter.sv
// rtc_downcounter: countdown timer on the packed RTC time word.
//   clk, reset         - clock, asynchronous active-high reset
//   wr, initialvalue   - load a duration (any state, returns to IDLE)
//   start / stop       - start-resume / pause requests (priority wr > stop > start)
//   clear_irq          - acknowledge of o_irq (also leaves EXPIRED)
//   o_sec..o_month     - remaining time fields (registered)
//   o_busy             - high while counting
//   o_expired          - one-cycle pulse when the count reaches zero
//   o_irq              - sticky expiry flag
module rtc_downcounter
  import rtc_pkg::*;
#(
  parameter int TICK_DIV = 100_000_000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr,
  input  logic [TIME_W-1:0] initialvalue,
  input  logic              start,
  input  logic              stop,
  input  logic              clear_irq,
  output logic [5:0]        o_sec,
  output logic [5:0]        o_min,
  output logic [4:0]        o_hour,
  output logic [4:0]        o_day,
  output logic [3:0]        o_month,
  output logic              o_busy,
  output logic              o_expired,
  output logic              o_irq
);

  rtc_state_e state_q;
  rtc_time_t  time_q;
  rtc_time_t  time_d;
  logic       busy_q, expired_q, irq_q;

  logic [5:0] sec, min;
  logic [4:0] hour, day;
  logic [3:0] mon;

  logic tick, pre_en, pre_clr;
  logic time_zero, dec_zero, expire_set;

  assign sec  = time_q[SEC_MSB:SEC_LSB];
  assign min  = time_q[MIN_MSB:MIN_LSB];
  assign hour = time_q[HOUR_MSB:HOUR_LSB];
  assign day  = time_q[DAY_MSB:DAY_LSB];
  assign mon  = time_q[MON_MSB:MON_LSB];

  // Prescaler runs only in RUN; a tick in a stop or wr cycle is discarded.
  // It holds its value in PAUSE so a resume does not lose part of a second.
  assign pre_en  = (state_q == ST_RUN) && !stop && !wr;
  assign pre_clr = wr || (state_q == ST_IDLE) || (state_q == ST_EXPIRED);

  rtc_tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk  (clk),
    .reset(reset),
    .clr  (pre_clr),
    .en   (pre_en),
    .tick (tick)
  );

  // Borrow chain: the lowest nonzero field decrements, everything below it
  // reloads to its maximum, everything above is untouched. All-zero holds.
  always_comb begin
    time_d = time_q;
    if (sec != '0) begin
      time_d = rtc_pack(mon, day, hour, min, sec - 6'd1);
    end else if (min != '0) begin
      time_d = rtc_pack(mon, day, hour, min - 6'd1, SEC_MAX);
    end else if (hour != '0) begin
      time_d = rtc_pack(mon, day, hour - 5'd1, MIN_MAX, SEC_MAX);
    end else if (day != '0) begin
      time_d = rtc_pack(mon, day - 5'd1, HOUR_MAX, MIN_MAX, SEC_MAX);
    end else if (mon != '0) begin
      time_d = rtc_pack(mon - 4'd1, DAY_MAX, HOUR_MAX, MIN_MAX, SEC_MAX);
    end
  end

  assign time_zero = (time_q == '0);
  assign dec_zero  = (time_d == '0);

  // Expiry: a start on an empty count, or a tick that lands on zero.
  assign expire_set = !wr && !stop &&
                      (((state_q == ST_IDLE) && start && time_zero) ||
                       ((state_q == ST_RUN) && tick && dec_zero));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      time_q    <= '0;
      busy_q    <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      expired_q <= expire_set;
      // Set beats a simultaneous clear_irq.
      irq_q     <= expire_set || (irq_q && !clear_irq);
      if (wr) begin
        time_q  <= initialvalue;
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!stop && start) begin
              if (time_zero) begin
                state_q <= ST_EXPIRED;
                busy_q  <= 1'b0;
              end else begin
                state_q <= ST_RUN;
                busy_q  <= 1'b1;
              end
            end
          end
          ST_RUN: begin
            if (stop) begin
              state_q <= ST_PAUSE;
              busy_q  <= 1'b0;
            end else if (tick) begin
              time_q <= time_d;
              if (dec_zero) begin
                state_q <= ST_EXPIRED;
                busy_q  <= 1'b0;
              end
            end
          end
          ST_PAUSE: begin
            if (!stop && start) begin
              state_q <= ST_RUN;
              busy_q  <= 1'b1;
            end
          end
          ST_EXPIRED: begin
            if (clear_irq) begin
              state_q <= ST_IDLE;
              busy_q  <= 1'b0;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_sec     = sec;
  assign o_min     = min;
  assign o_hour    = hour;
  assign o_day     = day;
  assign o_month   = mon;
  assign o_busy    = busy_q;
  assign o_expired = expired_q;
  assign o_irq     = irq_q;

endmodule

// File: tb/tb_rtc_downcounter.sv
// Testbench for rtc_downcounter with TICK_DIV=2. Each driven cycle pushes
// the expected post-edge outputs to a scoreboard queue; a negedge monitor
// pops and compares them. Expected time words come from a remaining-seconds
// model (mixed radix 60/60/24/31/12).
module tb_rtc_downcounter;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        wr = 1'b0;
  logic [25:0] initialvalue = '0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        clear_irq = 1'b0;
  logic [5:0]  o_sec, o_min;
  logic [4:0]  o_hour, o_day;
  logic [3:0]  o_month;
  logic        o_busy, o_expired, o_irq;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    string       tag;
    logic [25:0] t;
    logic        busy;
    logic        expd;
    logic        irq;
  } exp_t;

  exp_t sb_q[$];

  rtc_downcounter #(.TICK_DIV(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .wr          (wr),
    .initialvalue(initialvalue),
    .start       (start),
    .stop        (stop),
    .clear_irq   (clear_irq),
    .o_sec       (o_sec),
    .o_min       (o_min),
    .o_hour      (o_hour),
    .o_day       (o_day),
    .o_month     (o_month),
    .o_busy      (o_busy),
    .o_expired   (o_expired),
    .o_irq       (o_irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [25:0] from_secs(input int unsigned r);
    logic [5:0] s, m;
    logic [4:0] h, d;
    logic [3:0] mo;
    s  = 6'(r % 60);
    m  = 6'((r / 60) % 60);
    h  = 5'((r / 3600) % 24);
    d  = 5'((r / 86400) % 31);
    mo = 4'(r / (86400 * 31));
    return {mo, d, h, m, s};
  endfunction

  function automatic logic [25:0] obs_time();
    return {o_month, o_day, o_hour, o_min, o_sec};
  endfunction

  // Advance one clock edge with the inputs currently driven and queue the
  // outputs required after that edge.
  task automatic step(input string tag, input logic [25:0] et,
                      input logic eb, input logic ee, input logic ei);
    exp_t x;
    @(posedge clk);
    #1;
    x.tag = tag; x.t = et; x.busy = eb; x.expd = ee; x.irq = ei;
    sb_q.push_back(x);
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check({x.tag, ".time"},    32'(obs_time()), 32'(x.t));
      check({x.tag, ".busy"},    32'(o_busy),     32'(x.busy));
      check({x.tag, ".expired"}, 32'(o_expired),  32'(x.expd));
      check({x.tag, ".irq"},     32'(o_irq),      32'(x.irq));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned rem;
    // Reset state
    #12;
    check("reset.time",    32'(obs_time()), 32'd0);
    check("reset.busy",    32'(o_busy),     32'd0);
    check("reset.expired", 32'(o_expired),  32'd0);
    check("reset.irq",     32'(o_irq),      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    // sec=3 countdown: decrements at 2-cycle spacing, expires on reaching 0
    wr = 1'b1; initialvalue = from_secs(3);
    step("t1_load", from_secs(3), 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t1_start", from_secs(3), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      rem = 3 - k / 2;
      step($sformatf("t1_run%0d", k), from_secs(rem), (k < 6), (k == 6), (k == 6));
    end
    step("t1_after", '0, 1'b0, 1'b0, 1'b1);
    start = 1'b1;
    step("t1_start_in_expired", '0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; clear_irq = 1'b1;
    step("t1_clear", '0, 1'b0, 1'b0, 1'b0);
    clear_irq = 1'b0;

    // min=1 sec=0: borrow to 0:59, expiry after 60 ticks
    wr = 1'b1; initialvalue = from_secs(60);
    step("t2_load", from_secs(60), 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t2_start", from_secs(60), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    for (int k = 1; k <= 120; k++) begin
      rem = 60 - k / 2;
      step($sformatf("t2_run%0d", k), from_secs(rem), (k < 120), (k == 120), (k == 120));
    end
    clear_irq = 1'b1;
    step("t2_clear", '0, 1'b0, 1'b0, 1'b0);
    clear_irq = 1'b0;

    // month=1: full borrow chain to 0:30:23:59:59, then stop into PAUSE
    wr = 1'b1; initialvalue = from_secs(31 * 86400);
    step("t3_load", from_secs(31 * 86400), 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t3_start", from_secs(31 * 86400), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t3_run1", from_secs(31 * 86400), 1'b1, 1'b0, 1'b0);
    step("t3_run2", from_secs(31 * 86400 - 1), 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step("t3_stop", from_secs(31 * 86400 - 1), 1'b0, 1'b0, 1'b0);
    stop = 1'b0;

    // Pause: stop on the tick cycle, hold 20 cycles, resume decrements 1 cycle later
    wr = 1'b1; initialvalue = from_secs(10);
    step("t4_load", from_secs(10), 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t4_start", from_secs(10), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_run1", from_secs(10), 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step("t4_stop", from_secs(10), 1'b0, 1'b0, 1'b0);
    stop = 1'b0;
    for (int k = 0; k < 20; k++) begin
      step($sformatf("t4_hold%0d", k), from_secs(10), 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1;
    step("t4_resume", from_secs(10), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t4_dec1", from_secs(9), 1'b1, 1'b0, 1'b0);
    step("t4_dec1b", from_secs(9), 1'b1, 1'b0, 1'b0);
    step("t4_dec2", from_secs(8), 1'b1, 1'b0, 1'b0);

    // All-zero start, start ignored in EXPIRED, set beats clear
    wr = 1'b1; initialvalue = '0;
    step("t5_load", '0, 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t5_zero_start", '0, 1'b0, 1'b1, 1'b1);
    step("t5_start_again", '0, 1'b0, 1'b0, 1'b1);
    start = 1'b0; wr = 1'b1;
    step("t5_wr_keeps_irq", '0, 1'b0, 1'b0, 1'b1);
    wr = 1'b0; start = 1'b1; clear_irq = 1'b1;
    step("t5_set_beats_clear", '0, 1'b0, 1'b1, 1'b1);
    start = 1'b0;
    step("t5_clear", '0, 1'b0, 1'b0, 1'b0);
    clear_irq = 1'b0;

    // wr during RUN on the tick cycle: load wins, back to IDLE, no decrement
    wr = 1'b1; initialvalue = from_secs(5);
    step("t6_load", from_secs(5), 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t6_start", from_secs(5), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_run1", from_secs(5), 1'b1, 1'b0, 1'b0);
    wr = 1'b1; initialvalue = from_secs(300);
    step("t6_wr_run", from_secs(300), 1'b0, 1'b0, 1'b0);
    wr = 1'b0;
    for (int k = 0; k < 4; k++) begin
      step($sformatf("t6_idle%0d", k), from_secs(300), 1'b0, 1'b0, 1'b0);
    end
    start = 1'b1;
    step("t6_start2", from_secs(300), 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t6_run2a", from_secs(300), 1'b1, 1'b0, 1'b0);
    step("t6_run2b", from_secs(299), 1'b1, 1'b0, 1'b0);

    // Asynchronous reset mid-RUN: outputs clear before any clock edge
    @(negedge clk); #1;
    reset = 1'b1;
    #1;
    check("t6_async.time",    32'(obs_time()), 32'd0);
    check("t6_async.busy",    32'(o_busy),     32'd0);
    check("t6_async.expired", 32'(o_expired),  32'd0);
    check("t6_async.irq",     32'(o_irq),      32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    step("t6_post_reset", '0, 1'b0, 1'b0, 1'b0);

    // Out-of-range sec=63 decrements normally
    wr = 1'b1; initialvalue = 26'd63;
    step("t7_load", 26'd63, 1'b0, 1'b0, 1'b0);
    wr = 1'b0; start = 1'b1;
    step("t7_start", 26'd63, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    step("t7_run1", 26'd63, 1'b1, 1'b0, 1'b0);
    step("t7_run2", 26'd62, 1'b1, 1'b0, 1'b0);

    @(negedge clk); #1;
    check("sb_drain", 32'(sb_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
